regfile_wb_arbiter: RTL and testbench

- Shares the single register-file write port (WE3/AD3/WD3) between two writeback requesters: the ALU result path and the load/memory return path.
- Arbitrates round-robin with valid/ready handshakes and registers the winning write onto the port.
- Keeps a 32-entry scoreboard of registers with outstanding loads so issue logic can stall on read-after-write hazards.
- Sits between execute/memory stages and the register file.

---
 rtl/regfile_wb_arbiter.sv | 114 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin ALU/load writeback arbiter with load scoreboard
// Optional conflict counter under WB_CONFLICT_CNT_EN.
module regfile_wb_arbiter #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          alu_valid,
  input  logic [ADDRESS_WIDTH-1:0]      alu_rd,
  input  logic [DATA_WIDTH-1:0]         alu_data,
  output logic                          alu_ready,
  input  logic                          mem_valid,
  input  logic [ADDRESS_WIDTH-1:0]      mem_rd,
  input  logic [DATA_WIDTH-1:0]         mem_data,
  output logic                          mem_ready,
  input  logic                          issue_valid,
  input  logic [ADDRESS_WIDTH-1:0]      issue_rd,
  output logic                          issue_ready,
  output logic                          we3,
  output logic [ADDRESS_WIDTH-1:0]      wa3,
  output logic [DATA_WIDTH-1:0]         wd3,
  output logic [(2**ADDRESS_WIDTH)-1:0] busy,
  output logic [15:0]                   conflict_cnt
);

  localparam int NREG = 2 ** ADDRESS_WIDTH;
  localparam logic [0:0] PTR_ALU = 1'b0;
  localparam logic [0:0] PTR_MEM = 1'b1;

  logic [0:0]              ptr_q, ptr_d;
  logic                    we3_q, we3_d;
  logic [ADDRESS_WIDTH-1:0] wa3_q, wa3_d;
  logic [DATA_WIDTH-1:0]   wd3_q, wd3_d;
  logic [NREG-1:0]         busy_q, busy_d;

  logic alu_grant, mem_grant, issue_set;

  // The pointer only matters when both requesters compete.
  assign alu_grant = alu_valid && (!mem_valid || (ptr_q == PTR_ALU));
  assign mem_grant = mem_valid && (!alu_valid || (ptr_q == PTR_MEM));
  assign alu_ready = alu_grant;
  assign mem_ready = mem_grant;

  // No bypass of a clear landing this cycle: issue stalls one extra cycle.
  assign issue_ready = !busy_q[issue_rd];
  assign issue_set   = issue_valid && issue_ready && (issue_rd != '0);

  always_comb begin
    ptr_d = ptr_q;
    we3_d = 1'b0;
    wa3_d = wa3_q;
    wd3_d = wd3_q;
    if (alu_grant) begin
      ptr_d = PTR_MEM;
      we3_d = (alu_rd != '0);
      wa3_d = alu_rd;
      wd3_d = alu_data;
    end else if (mem_grant) begin
      ptr_d = PTR_ALU;
      we3_d = (mem_rd != '0);
      wa3_d = mem_rd;
      wd3_d = mem_data;
    end
  end

  // Set is applied after clear so a same-index collision leaves the bit set.
  always_comb begin
    busy_d = busy_q;
    if (mem_grant) busy_d[mem_rd] = 1'b0;
    if (issue_set) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q  <= PTR_ALU;
      we3_q  <= 1'b0;
      wa3_q  <= '0;
      wd3_q  <= '0;
      busy_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      we3_q  <= we3_d;
      wa3_q  <= wa3_d;
      wd3_q  <= wd3_d;
      busy_q <= busy_d;
    end
  end

  assign we3  = we3_q;
  assign wa3  = wa3_q;
  assign wd3  = wd3_q;
  assign busy = busy_q;

`ifdef WB_CONFLICT_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (alu_valid && mem_valid && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign conflict_cnt = cnt_q;
`else
  assign conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, mem_valid, issue_valid;
  logic [4:0]  alu_rd, mem_rd, issue_rd;
  logic [31:0] alu_data, mem_data;
  logic        alu_ready, mem_ready, issue_ready;
  logic        we3;
  logic [4:0]  wa3;
  logic [31:0] wd3;
  logic [31:0] busy;
  logic [15:0] conflict_cnt;

  int checks = 0;
  int errors = 0;

  regfile_wb_arbiter #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .we3(we3), .wa3(wa3), .wd3(wd3), .busy(busy), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    mem_valid = 0; mem_rd = 0; mem_data = 0;
    issue_valid = 0; issue_rd = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    rst = 0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (we3 !== 1'b0) begin errors++; $display("FAIL reset_we3 got %0b want 0", we3); end
    checks++; if (wa3 !== 5'd0) begin errors++; $display("FAIL reset_wa3 got %0d want 0", wa3); end
    checks++; if (wd3 !== 32'd0) begin errors++; $display("FAIL reset_wd3 got %h want 0", wd3); end
    checks++; if (busy !== 32'd0) begin errors++; $display("FAIL reset_busy got %h want 0", busy); end
    checks++; if (conflict_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", conflict_cnt); end
    checks++; if ({alu_ready, mem_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready got %b want 00", {alu_ready, mem_ready}); end
  endtask

  task automatic test_single_alu();
    do_reset();
    alu_valid = 1; alu_rd = 5; alu_data = 32'h1234;
    #1;
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL single_alu_ready got %0b want 1", alu_ready); end
    tick();
    idle_inputs();
    checks++; if ({we3, wa3, wd3} !== {1'b1, 5'd5, 32'h1234}) begin
      errors++; $display("FAIL single_write got we=%0b a=%0d d=%h want we=1 a=5 d=1234", we3, wa3, wd3); end
    tick();
    checks++; if ({we3, wa3, wd3} !== {1'b0, 5'd5, 32'h1234}) begin
      errors++; $display("FAIL single_idle got we=%0b a=%0d d=%h want we=0 a=5 d=1234", we3, wa3, wd3); end
  endtask

  task automatic test_round_robin();
    logic [1:0]  exp_rdy [4];
    logic [4:0]  exp_wa  [4];
    logic [31:0] exp_wd  [4];
    logic [15:0] exp_cnt;
    exp_rdy[0] = 2'b10; exp_rdy[1] = 2'b01; exp_rdy[2] = 2'b10; exp_rdy[3] = 2'b01;
    exp_wa[0] = 5'd1; exp_wa[1] = 5'd2; exp_wa[2] = 5'd1; exp_wa[3] = 5'd2;
    exp_wd[0] = 32'hAAAA0001; exp_wd[1] = 32'hBBBB0002; exp_wd[2] = 32'hAAAA0001; exp_wd[3] = 32'hBBBB0002;
`ifdef WB_CONFLICT_CNT_EN
    exp_cnt = 16'd4;
`else
    exp_cnt = 16'd0;
`endif
    do_reset();
    alu_valid = 1; alu_rd = 1; alu_data = 32'hAAAA0001;
    mem_valid = 1; mem_rd = 2; mem_data = 32'hBBBB0002;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if ({alu_ready, mem_ready} !== exp_rdy[i]) begin
        errors++; $display("FAIL rr_grant[%0d] got %b want %b", i, {alu_ready, mem_ready}, exp_rdy[i]); end
      tick();
      checks++; if ({we3, wa3, wd3} !== {1'b1, exp_wa[i], exp_wd[i]}) begin
        errors++; $display("FAIL rr_write[%0d] got we=%0b a=%0d d=%h want we=1 a=%0d d=%h", i, we3, wa3, wd3, exp_wa[i], exp_wd[i]); end
    end
    idle_inputs();
    #1;
    checks++; if (conflict_cnt !== exp_cnt) begin errors++; $display("FAIL rr_conflict_cnt got %0d want %0d", conflict_cnt, exp_cnt); end
    tick();
    checks++; if (conflict_cnt !== exp_cnt) begin errors++; $display("FAIL rr_conflict_hold got %0d want %0d", conflict_cnt, exp_cnt); end
  endtask

  task automatic test_scoreboard();
    do_reset();
    issue_valid = 1; issue_rd = 7;
    #1;
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL sb_issue_ready0 got %0b want 1", issue_ready); end
    tick();
    checks++; if (busy !== 32'h0000_0080) begin errors++; $display("FAIL sb_busy_set got %h want 00000080", busy); end
    checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL sb_issue_stall got %0b want 0", issue_ready); end
    mem_valid = 1; mem_rd = 7; mem_data = 32'hC0FFEE07;
    #1;
    checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL sb_mem_ready got %0b want 1", mem_ready); end
    checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL sb_no_bypass got %0b want 0", issue_ready); end
    tick();
    mem_valid = 0;
    #1;
    checks++; if (busy !== 32'd0) begin errors++; $display("FAIL sb_busy_clear got %h want 0", busy); end
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL sb_issue_resume got %0b want 1", issue_ready); end
    checks++; if ({we3, wa3, wd3} !== {1'b1, 5'd7, 32'hC0FFEE07}) begin
      errors++; $display("FAIL sb_mem_write got we=%0b a=%0d d=%h want we=1 a=7 d=c0ffee07", we3, wa3, wd3); end
    idle_inputs();
  endtask

  task automatic test_set_wins();
    do_reset();
    issue_valid = 1; issue_rd = 9;
    mem_valid = 1; mem_rd = 9; mem_data = 32'h0000_0909;
    tick();
    idle_inputs();
    checks++; if (busy !== 32'h0000_0200) begin errors++; $display("FAIL setwins_busy got %h want 00000200", busy); end
    checks++; if ({we3, wa3} !== {1'b1, 5'd9}) begin errors++; $display("FAIL setwins_write got we=%0b a=%0d want we=1 a=9", we3, wa3); end
    tick();
    checks++; if (busy !== 32'h0000_0200) begin errors++; $display("FAIL setwins_hold got %h want 00000200", busy); end
  endtask

  task automatic test_x0();
    do_reset();
    alu_valid = 1; alu_rd = 0; alu_data = 32'hFFFF_FFFF;
    issue_valid = 1; issue_rd = 0;
    #1;
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL x0_ready got %0b want 1", alu_ready); end
    tick();
    idle_inputs();
    checks++; if (we3 !== 1'b0) begin errors++; $display("FAIL x0_we3 got %0b want 0", we3); end
    checks++; if (busy !== 32'd0) begin errors++; $display("FAIL x0_busy got %h want 0", busy); end
    mem_valid = 1; mem_rd = 3; mem_data = 32'h3333;
    tick();
    idle_inputs();
    checks++; if ({we3, wa3, wd3, busy} !== {1'b1, 5'd3, 32'h3333, 32'd0}) begin
      errors++; $display("FAIL unbusy_mem got we=%0b a=%0d d=%h busy=%h want we=1 a=3 d=3333 busy=0", we3, wa3, wd3, busy); end
  endtask

  task automatic test_async_reset();
    do_reset();
    issue_valid = 1; issue_rd = 7;
    tick();
    issue_rd = 10;
    tick();
    issue_valid = 0;
    checks++; if (busy !== 32'h0000_0480) begin errors++; $display("FAIL ar_busy_pre got %h want 00000480", busy); end
    alu_valid = 1; alu_rd = 4; alu_data = 32'h4444;
    tick();
    idle_inputs();
    checks++; if (we3 !== 1'b1) begin errors++; $display("FAIL ar_we3_pre got %0b want 1", we3); end
    #2;
    rst = 1;
    #1;
    checks++; if ({we3, wa3, wd3, busy} !== 70'd0) begin
      errors++; $display("FAIL ar_async got we=%0b a=%0d d=%h busy=%h want all 0", we3, wa3, wd3, busy); end
    checks++; if (conflict_cnt !== 16'd0) begin errors++; $display("FAIL ar_cnt got %0d want 0", conflict_cnt); end
    tick();
    rst = 0;
  endtask

  initial begin
    rst = 0;
    idle_inputs();
    #2;
    test_reset();
    test_single_alu();
    test_round_robin();
    test_scoreboard();
    test_set_wins();
    test_x0();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end

endmodule
